fragment_writer: RTL

FRAGMENT_WRITER -- requirements
Module: fragment_writer

---
 rtl/fragment_pkg.sv | 49 ++++
 rtl/texel_address.sv | 64 ++++++
 rtl/fragment_writer.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fragment_pkg.sv
// Shared types for the fragment writer: depth compare codes, FSM states and Q16.16 unity.
// The StBlendRd state exists only when FRAGMENT_BLEND_EN is defined.
package fragment_pkg;

  localparam logic [31:0] ONE = 32'h0001_0000;

  typedef enum logic [2:0] {
    DfNever    = 3'd0,
    DfLess     = 3'd1,
    DfEqual    = 3'd2,
    DfLequal   = 3'd3,
    DfGreater  = 3'd4,
    DfNotequal = 3'd5,
    DfGequal   = 3'd6,
    DfAlways   = 3'd7
  } depth_func_e;

  typedef enum logic [3:0] {
    StIdle,
    StDepthRd,
    StDepthTest,
    StDepthWr,
    StTexAddr,
    StTexRd,
    StShade,
    StPixWr
`ifdef FRAGMENT_BLEND_EN
    , StBlendRd
`endif
  } state_e;

  // Fragment depth OP stored depth; true means the fragment survives.
  function automatic logic depth_pass(depth_func_e func, logic [15:0] frag, logic [15:0] stored);
    logic pass;
    pass = 1'b1;
    case (func)
      DfNever:    pass = 1'b0;
      DfLess:     pass = frag <  stored;
      DfEqual:    pass = frag == stored;
      DfLequal:   pass = frag <= stored;
      DfGreater:  pass = frag >  stored;
      DfNotequal: pass = frag != stored;
      DfGequal:   pass = frag >= stored;
      default:    pass = 1'b1;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/texel_address.sv
// Texel address pipeline: clamp/wrap s,t -> scale to u,v -> base + v*TEXTURE_WIDTH + u.
// Three register stages; inputs must stay stable for three cycles before addr_o is used.
module texel_address
  import fragment_pkg::*;
#(
  parameter int unsigned TEXTURE_WIDTH  = 32,
  parameter int unsigned TEXTURE_HEIGHT = 32
) (
  input  logic        clk,
  input  logic        reset_ni,
  input  logic [31:0] s_i,
  input  logic [31:0] t_i,
  input  logic [31:0] base_i,
  input  logic        clamp_s_i,
  input  logic        clamp_t_i,
  output logic [31:0] addr_o
);

  localparam int unsigned UBits = $clog2(TEXTURE_WIDTH);
  localparam int unsigned VBits = $clog2(TEXTURE_HEIGHT);
  localparam logic [31:0] UMax  = 32'(TEXTURE_WIDTH - 1);
  localparam logic [31:0] VMax  = 32'(TEXTURE_HEIGHT - 1);

  typedef logic [UBits-1:0] u_t;
  typedef logic [VBits-1:0] v_t;

  function automatic logic [15:0] fold(logic [31:0] c, logic clamp);
    logic [15:0] r;
    if (!clamp) begin
      r = c[15:0];
    end else if (c[31]) begin
      r = '0;
    end else if (c > ONE - 32'd1) begin
      r = 16'(ONE - 32'd1);
    end else begin
      r = c[15:0];
    end
    return r;
  endfunction

  logic [15:0] s_q, t_q;
  u_t          u_q;
  v_t          v_q;
  logic [31:0] addr_q;

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      s_q    <= '0;
      t_q    <= '0;
      u_q    <= '0;
      v_q    <= '0;
      addr_q <= '0;
    end else begin
      s_q    <= fold(s_i, clamp_s_i);
      t_q    <= fold(t_i, clamp_t_i);
      u_q    <= u_t'((32'(s_q) * UMax) >> 16);
      v_q    <= v_t'((32'(t_q) * VMax) >> 16);
      addr_q <= base_i + (32'(v_q) << UBits) + 32'(u_q);
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/fragment_writer.sv
// Per-fragment depth test, optional texture fetch, shading and pixel write over a VRAM port.
// Optional FRAGMENT_BLEND_EN adds a destination read and 50/50 RGB blend.
module fragment_writer
  import fragment_pkg::*;
#(
  parameter int unsigned FB_WIDTH       = 128,
  parameter int unsigned TEXTURE_WIDTH  = 32,
  parameter int unsigned TEXTURE_HEIGHT = 32
) (
  input  logic        clk,
  input  logic        reset_ni,
  input  logic        frag_valid_i,
  output logic        frag_ready_o,
  input  logic [15:0] frag_x_i,
  input  logic [15:0] frag_y_i,
  input  logic [31:0] frag_z_i,
  input  logic [31:0] frag_r_i,
  input  logic [31:0] frag_g_i,
  input  logic [31:0] frag_b_i,
  input  logic [31:0] frag_s_i,
  input  logic [31:0] frag_t_i,
  input  logic [31:0] depth_address_i,
  input  logic [31:0] texture_address_i,
  input  logic [31:0] back_address_i,
  input  logic [2:0]  depth_func_i,
  input  logic        depth_write_i,
  input  logic        is_textured_i,
  input  logic        is_clamp_s_i,
  input  logic        is_clamp_t_i,
`ifdef FRAGMENT_BLEND_EN
  input  logic        blend_i,
`endif
  output logic        vram_sel_o,
  output logic        vram_wr_o,
  output logic [3:0]  vram_mask_o,
  output logic [31:0] vram_addr_o,
  output logic [15:0] vram_data_out_o,
  input  logic [15:0] vram_data_in_i,
  input  logic        vram_ack_i,
  output logic        busy_o
);

  state_e      state_q;
  logic        ready_q, busy_q, sel_q, wr_q;
  logic [3:0]  mask_q;
  logic [31:0] addr_q;
  logic [15:0] data_q;
  logic [1:0]  cnt_q;

  depth_func_e func_q;
  logic        dw_q, tex_q, clamp_s_q, clamp_t_q;
  logic [15:0] x_q, y_q, z_q;
  logic [31:0] r_q, g_q, b_q, s_q, t_q;
  logic [31:0] depth_base_q, tex_base_q, back_base_q;
  logic [15:0] rdata_q, sample_q, pixel_q;
`ifdef FRAGMENT_BLEND_EN
  logic        blend_q;
`endif

  logic [31:0] pix_off, depth_addr, back_addr, tex_addr;
  logic [3:0]  shade_nib, shade_chan;
  logic [31:0] shade_col;
  logic [16:0] col_sat;
  logic [4:0]  shade_int;
  logic [15:0] wr_pixel;

  logic unused_bits;
  assign unused_bits = ^{frag_z_i[31:16], sample_q[15:12]};

  assign pix_off    = 32'(y_q) * FB_WIDTH + 32'(x_q);
  assign depth_addr = depth_base_q + pix_off;
  assign back_addr  = back_base_q + pix_off;

  texel_address #(
    .TEXTURE_WIDTH (TEXTURE_WIDTH),
    .TEXTURE_HEIGHT(TEXTURE_HEIGHT)
  ) u_texel_address (
    .clk      (clk),
    .reset_ni (reset_ni),
    .s_i      (s_q),
    .t_i      (t_q),
    .base_i   (tex_base_q),
    .clamp_s_i(clamp_s_q),
    .clamp_t_i(clamp_t_q),
    .addr_o   (tex_addr)
  );

  // One multiplier shared across R, G, B; cnt_q selects the channel.
  always_comb begin
    shade_nib = sample_q[3:0];
    shade_col = b_q;
    case (cnt_q)
      2'd0:    begin shade_nib = sample_q[11:8]; shade_col = r_q; end
      2'd1:    begin shade_nib = sample_q[7:4];  shade_col = g_q; end
      default: begin shade_nib = sample_q[3:0];  shade_col = b_q; end
    endcase
    if (shade_col[31]) begin
      col_sat = '0;
    end else if (shade_col > ONE) begin
      col_sat = ONE[16:0];
    end else begin
      col_sat = shade_col[16:0];
    end
    shade_int  = 5'((21'(shade_nib) * 21'(col_sat)) >> 16);
    shade_chan = (shade_int > 5'd15) ? 4'hF : shade_int[3:0];
  end

  always_comb begin
    wr_pixel = pixel_q;
`ifdef FRAGMENT_BLEND_EN
    if (blend_q) begin
      wr_pixel = {4'hF,
                  4'((5'(pixel_q[11:8]) + 5'(rdata_q[11:8])) >> 1),
                  4'((5'(pixel_q[7:4])  + 5'(rdata_q[7:4]))  >> 1),
                  4'((5'(pixel_q[3:0])  + 5'(rdata_q[3:0]))  >> 1)};
    end
`endif
  end

  // Access states launch on entry (sel_q low) and leave on the ack edge, which also drops sel.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= StIdle;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      sel_q        <= 1'b0;
      wr_q         <= 1'b0;
      mask_q       <= 4'hF;
      addr_q       <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      func_q       <= DfNever;
      dw_q         <= 1'b0;
      tex_q        <= 1'b0;
      clamp_s_q    <= 1'b0;
      clamp_t_q    <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      z_q          <= '0;
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
      s_q          <= '0;
      t_q          <= '0;
      depth_base_q <= '0;
      tex_base_q   <= '0;
      back_base_q  <= '0;
      rdata_q      <= '0;
      sample_q     <= '0;
      pixel_q      <= '0;
`ifdef FRAGMENT_BLEND_EN
      blend_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          ready_q <= 1'b1;
          if (frag_valid_i && ready_q) begin
            ready_q      <= 1'b0;
            busy_q       <= 1'b1;
            func_q       <= depth_func_e'(depth_func_i);
            dw_q         <= depth_write_i;
            tex_q        <= is_textured_i;
            clamp_s_q    <= is_clamp_s_i;
            clamp_t_q    <= is_clamp_t_i;
            x_q          <= frag_x_i;
            y_q          <= frag_y_i;
            z_q          <= frag_z_i[15:0];
            r_q          <= frag_r_i;
            g_q          <= frag_g_i;
            b_q          <= frag_b_i;
            s_q          <= frag_s_i;
            t_q          <= frag_t_i;
            depth_base_q <= depth_address_i;
            tex_base_q   <= texture_address_i;
            back_base_q  <= back_address_i;
`ifdef FRAGMENT_BLEND_EN
            blend_q      <= blend_i;
`endif
            if (depth_func_i == DfAlways || depth_func_i == DfNever) begin
              state_q <= StDepthTest;
            end else begin
              state_q <= StDepthRd;
            end
          end
        end
        StDepthRd: begin
          if (!sel_q) begin
            sel_q  <= 1'b1;
            wr_q   <= 1'b0;
            mask_q <= 4'hF;
            addr_q <= depth_addr;
            data_q <= '0;
          end else if (vram_ack_i) begin
            sel_q   <= 1'b0;
            rdata_q <= vram_data_in_i;
            state_q <= StDepthTest;
          end
        end
        StDepthTest: begin
          cnt_q <= '0;
          if (!depth_pass(func_q, z_q, rdata_q)) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else if (dw_q) begin
            state_q <= StDepthWr;
          end else begin
            state_q <= StTexAddr;
          end
        end
        StDepthWr: begin
          if (!sel_q) begin
            sel_q  <= 1'b1;
            wr_q   <= 1'b1;
            mask_q <= 4'hF;
            addr_q <= depth_addr;
            data_q <= z_q;
          end else if (vram_ack_i) begin
            sel_q   <= 1'b0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= StTexAddr;
          end
        end
        StTexAddr: begin
          // Waits out the texel_address pipeline so every fragment sees the same timing.
          if (cnt_q == 2'd2) begin
            cnt_q <= '0;
            if (tex_q) begin
              state_q <= StTexRd;
            end else begin
              sample_q <= 16'hFFFF;
              state_q  <= StShade;
            end
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        StTexRd: begin
          if (!sel_q) begin
            sel_q  <= 1'b1;
            wr_q   <= 1'b0;
            mask_q <= 4'hF;
            addr_q <= tex_addr;
            data_q <= '0;
          end else if (vram_ack_i) begin
            sel_q    <= 1'b0;
            sample_q <= vram_data_in_i;
            cnt_q    <= '0;
            state_q  <= StShade;
          end
        end
        StShade: begin
          case (cnt_q)
            2'd0:    pixel_q[11:8] <= shade_chan;
            2'd1:    pixel_q[7:4]  <= shade_chan;
            default: pixel_q[3:0]  <= shade_chan;
          endcase
          if (cnt_q == 2'd2) begin
            pixel_q[15:12] <= 4'hF;
            cnt_q          <= '0;
`ifdef FRAGMENT_BLEND_EN
            state_q        <= blend_q ? StBlendRd : StPixWr;
`else
            state_q        <= StPixWr;
`endif
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
`ifdef FRAGMENT_BLEND_EN
        StBlendRd: begin
          if (!sel_q) begin
            sel_q  <= 1'b1;
            wr_q   <= 1'b0;
            mask_q <= 4'hF;
            addr_q <= back_addr;
            data_q <= '0;
          end else if (vram_ack_i) begin
            sel_q   <= 1'b0;
            rdata_q <= vram_data_in_i;
            state_q <= StPixWr;
          end
        end
`endif
        StPixWr: begin
          if (!sel_q) begin
            sel_q  <= 1'b1;
            wr_q   <= 1'b1;
            mask_q <= 4'hF;
            addr_q <= back_addr;
            data_q <= wr_pixel;
          end else if (vram_ack_i) begin
            sel_q   <= 1'b0;
            wr_q    <= 1'b0;
            state_q <= StIdle;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          sel_q   <= 1'b0;
          wr_q    <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign frag_ready_o    = ready_q;
  assign busy_o          = busy_q;
  assign vram_sel_o      = sel_q;
  assign vram_wr_o       = wr_q;
  assign vram_mask_o     = mask_q;
  assign vram_addr_o     = addr_q;
  assign vram_data_out_o = data_q;

endmodule
